// File: rtl/matmul_engine.sv
// matmul_engine: NxN output-stationary systolic matrix multiplier.
// Streams in W then X (row-major), computes X*W or X*W^T, and streams C out
// (row-major) with an optional ReLU applied first.
// Optional build macro MATMUL_SAT_EN: results saturate to the signed DW range
// instead of being truncated to their low DW bits.

// One processing element: multiply-accumulate on the operands presented to it.
module matmul_pe #(
  parameter int DW   = 8,
  parameter int ACCW = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);
  logic signed [2*DW-1:0] prod;

  assign prod = a * b;

  // Accumulate at full precision; cleared when a new operation starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + ACCW'(prod);
  end
endmodule

module matmul_engine #(
  parameter int N    = 2,
  parameter int DW   = 8,
  parameter int ACCW = 2*DW + $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          transpose,
  input  logic          activation,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          done
);
  localparam int NN = N*N;
  localparam int LW = $clog2(2*NN);
  localparam int CW = $clog2(3*N);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUT} state_t;

  state_t state, state_nx;
  logic          rdy_en;
  logic [LW-1:0] lcnt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] oi, oj;
  logic          tr_l, act_l;
  logic          xfer, last_xfer, comp_en, ohs, last_out;

  // W lives at 0..NN-1, X at NN..2*NN-1, both row-major.
  logic [DW-1:0] mem [2*NN];

  logic [N-1:0][DW-1:0]         a_feed, b_feed;
  logic [N-1:0][N-1:0][DW-1:0]  a_dly, b_dly;
  logic [N-1:0][N-1:0][ACCW-1:0] acc;

  logic signed [ACCW-1:0] acc_sel, acc_act;
  logic [DW-1:0]          fmt;

  assign in_ready  = rdy_en && (state == IDLE || state == LOAD);
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (lcnt == LW'(2*NN-1));
  assign comp_en   = (state == COMPUTE);
  assign out_valid = (state == OUT);
  assign ohs       = out_valid && out_ready;
  assign last_out  = ohs && (oi == IW'(N-1)) && (oj == IW'(N-1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: the compute phase ends once the last skewed operand pair
  // has reached the bottom-right PE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (xfer) state_nx = LOAD;
      LOAD:    if (last_xfer) state_nx = COMPUTE;
      COMPUTE: if (cnt == CW'(3*N-2)) state_nx = OUT;
      OUT:     if (last_out) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Hold off in_ready until the first edge after reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Load counter walks W then X and wraps for the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lcnt <= '0;
    else if (xfer) lcnt <= last_xfer ? '0 : lcnt + 1'b1;
  end

  // Operand storage; every operation rewrites all entries, so no reset.
  always_ff @(posedge clk) begin
    if (xfer) mem[lcnt] <= in_data;
  end

  // Mode bits are sampled with the final load element only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tr_l  <= 1'b0;
      act_l <= 1'b0;
    end else if (last_xfer) begin
      tr_l  <= transpose;
      act_l <= activation;
    end
  end

  // Compute cycle counter drives the skewed feed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (last_xfer) cnt <= '0;
    else if (comp_en)   cnt <= cnt + 1'b1;
  end

  // Skewed edge feed: row r of X and column r of B start r cycles late,
  // where B is W or W^T; zeros outside each window.
  always_comb begin
    a_feed = '0;
    b_feed = '0;
    if (comp_en) begin
      for (int r = 0; r < N; r++) begin
        if (int'(cnt) >= r && int'(cnt) < r + N) begin
          a_feed[r] = mem[LW'(NN + r*N + int'(cnt) - r)];
          b_feed[r] = tr_l ? mem[LW'(r*N + int'(cnt) - r)]
                           : mem[LW'((int'(cnt) - r)*N + r)];
        end
      end
    end
  end

  // Operand shift chains: a moves right along each row, b down each column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dly <= '0;
      b_dly <= '0;
    end else if (last_xfer) begin
      a_dly <= '0;
      b_dly <= '0;
    end else if (comp_en) begin
      for (int r = 0; r < N; r++) begin
        a_dly[r][0] <= a_feed[r];
        b_dly[r][0] <= b_feed[r];
        for (int s = 1; s < N; s++) begin
          a_dly[r][s] <= a_dly[r][s-1];
          b_dly[r][s] <= b_dly[r][s-1];
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      matmul_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (last_xfer),
        .en    (comp_en),
        .a     (a_dly[i][j]),
        .b     (b_dly[j][i]),
        .acc   (acc[i][j])
      );
    end
  end

  // Result index, row-major; advances only on an accepted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oi <= '0;
      oj <= '0;
    end else if (ohs) begin
      if (oj == IW'(N-1)) begin
        oj <= '0;
        oi <= (oi == IW'(N-1)) ? '0 : oi + 1'b1;
      end else begin
        oj <= oj + 1'b1;
      end
    end
  end

  // Single-cycle completion pulse after the last result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= last_out;
  end

  assign acc_sel = acc[oi][oj];
  assign acc_act = (act_l && acc_sel[ACCW-1]) ? '0 : acc_sel;

`ifdef MATMUL_SAT_EN
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  // Clamp to the signed output range.
  always_comb begin
    fmt = acc_act[DW-1:0];
    if (acc_act > SMAX)      fmt = SMAX[DW-1:0];
    else if (acc_act < SMIN) fmt = SMIN[DW-1:0];
  end
`else
  logic unused_hi;

  // Upper accumulator bits are deliberately dropped by truncation.
  assign fmt       = acc_act[DW-1:0];
  assign unused_hi = ^acc_act[ACCW-1:DW];
`endif

  assign out_data = out_valid ? fmt : '0;
endmodule

// File: tb/tb_matmul_engine.sv
// Bench for matmul_engine: directed known-answer cases, randomized operations
// against a plain-arithmetic matrix model, stalls, back-to-back and reset abort.
module tb_matmul_engine;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int NN = N*N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          transpose = 1'b0;
  logic          activation = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, done;
  logic [DW-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int xfer_cyc = 0;
  int nxt_w0 = 0;
  int cur_w[NN];
  int cur_x[NN];
  bit cur_tr, cur_act;
  logic [DW-1:0] exp_q[$];

  matmul_engine #(.N(N), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .transpose  (transpose),
    .activation (activation),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  // Reference: C = X * B with B = W or W^T, then ReLU, then format.
  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int s = 0;
        for (int k = 0; k < N; k++)
          s += cur_x[i*N+k] * (cur_tr ? cur_w[j*N+k] : cur_w[k*N+j]);
        if (cur_act && s < 0) s = 0;
`ifdef MATMUL_SAT_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`endif
        exp_q.push_back(DW'(s));
      end
  endtask

  task automatic set_exp(input int e0, input int e1, input int e2, input int e3);
    exp_q.delete();
    exp_q.push_back(DW'(e0)); exp_q.push_back(DW'(e1));
    exp_q.push_back(DW'(e2)); exp_q.push_back(DW'(e3));
  endtask

  task automatic rand_op();
    for (int e = 0; e < NN; e++) begin
      cur_w[e] = int'($urandom_range(0, 255)) - 128;
      cur_x[e] = int'($urandom_range(0, 255)) - 128;
    end
    cur_tr  = 1'($urandom_range(0, 1));
    cur_act = 1'($urandom_range(0, 1));
    build_exp();
  endtask

  task automatic send(input int d, input bit tr, input bit act);
    int g = 0;
    @(negedge clk);
    in_data = DW'(d); in_valid = 1'b1; transpose = tr; activation = act;
    while (!in_ready && g < 20) begin @(negedge clk); g++; end
    n_cmp++;
    if (g >= 20) begin n_err++; $display("FAIL in_ready_wait got 0 want 1"); end
    @(posedge clk); #1;
    xfer_cyc = cyc;
    in_valid = 1'b0;
  endtask

  // Mode inputs are random except on the final element, then flipped.
  task automatic load_op(input int start, input bit gaps);
    for (int e = start; e < 2*NN; e++) begin
      bit last = (e == 2*NN-1);
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
      send(e < NN ? cur_w[e] : cur_x[e-NN],
           last ? cur_tr  : 1'($urandom_range(0, 1)),
           last ? cur_act : 1'($urandom_range(0, 1)));
    end
    transpose  = ~cur_tr;
    activation = ~cur_act;
  endtask

  task automatic collect(input bit rnd, input int stall_at, input bit b2b);
    int idx = 0;
    int budget = 0;
    int stall_n = 0;
    bit first = 1'b1;
    bit held = 1'b0;
    logic [DW-1:0] prev = '0;
    while (idx < NN && budget < 500) begin
      @(negedge clk); budget++;
      if (first && out_valid) begin
        first = 1'b0; n_cmp++;
        if (cyc - xfer_cyc + 1 != 3*N) begin
          n_err++; $display("FAIL latency got %0d want %0d", cyc - xfer_cyc + 1, 3*N);
        end
      end
      if (held) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== prev) begin
          n_err++;
          $display("FAIL stall_hold got v=%b d=%h want v=1 d=%h", out_valid, out_data, prev);
        end
      end
      if (out_valid && stall_at == idx && stall_n < 20) begin
        stall_n++; out_ready = 1'b0;
        in_valid = 1'($urandom_range(0, 1)); in_data = DW'($urandom);
      end else begin
        in_valid  = (stall_at >= 0 && !out_valid) ? 1'($urandom_range(0, 1)) : 1'b0;
        in_data   = DW'($urandom);
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      held = out_valid && !out_ready;
      prev = out_data;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== exp_q[idx]) begin
          n_err++; $display("FAIL result[%0d] got %h want %h", idx, out_data, exp_q[idx]);
        end
        idx++;
      end
    end
    in_valid = 1'b0;
    if (idx < NN) begin n_cmp++; n_err++; $display("FAIL out_timeout got %0d want %0d", idx, NN); end
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL done_cycle got done=%b ov=%b ir=%b want 1 0 1", done, out_valid, in_ready);
    end
    if (b2b) begin
      in_data = DW'(nxt_w0); in_valid = 1'b1; transpose = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL done_width got 1 want 0"); end
    end
  endtask

  task automatic check_reset_outs(input string tag);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_data !== '0) begin
      n_err++;
      $display("FAIL %s got ir=%b ov=%b dn=%b od=%h want 0 0 0 00", tag, in_ready, out_valid, done, out_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release got %b want 1", in_ready); end
  endtask

  task automatic test_known_answers();
    cur_w = '{1, 2, 3, 4}; cur_x = '{5, 6, 7, 8};
    cur_tr = 1'b0; cur_act = 1'b0; set_exp(23, 34, 31, 46);
    load_op(0, 1'b0); collect(1'b0, -1, 1'b0);
    cur_tr = 1'b1; set_exp(17, 39, 23, 53);
    load_op(0, 1'b0); collect(1'b0, -1, 1'b0);
  endtask

  task automatic test_relu();
    cur_w = '{-1, 0, 0, -1}; cur_x = '{3, 0, 0, 3}; cur_tr = 1'b0;
    cur_act = 1'b1; set_exp(0, 0, 0, 0);
    load_op(0, 1'b0); collect(1'b0, -1, 1'b0);
    cur_act = 1'b0; set_exp(8'hFD, 0, 0, 8'hFD);
    load_op(0, 1'b0); collect(1'b0, -1, 1'b0);
  endtask

  task automatic test_overflow();
    cur_w = '{127, 127, 127, 127}; cur_x = '{127, 127, 127, 127};
    cur_tr = 1'b0; cur_act = 1'b0;
`ifdef MATMUL_SAT_EN
    set_exp(8'h7F, 8'h7F, 8'h7F, 8'h7F);
`else
    set_exp(8'h02, 8'h02, 8'h02, 8'h02);
`endif
    load_op(0, 1'b0); collect(1'b0, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      rand_op(); load_op(0, 1'b1); collect(1'b1, -1, 1'b0);
    end
  endtask

  task automatic test_stall();
    rand_op(); load_op(0, 1'b1); collect(1'b1, 1, 1'b0);
    rand_op(); load_op(0, 1'b0); collect(1'b0, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    nxt_w0 = int'($urandom_range(0, 255)) - 128;
    rand_op(); load_op(0, 1'b0); collect(1'b0, -1, 1'b1);
    rand_op(); cur_w[0] = nxt_w0; build_exp();
    load_op(1, 1'b0); collect(1'b1, -1, 1'b0);
  endtask

  task automatic test_reset_abort();
    rand_op();
    for (int e = 0; e < 5; e++) send(e < NN ? cur_w[e] : cur_x[e-NN], 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); check_reset_outs("abort_in_reset");
    @(negedge clk); check_reset_outs("abort_in_reset2");
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL abort_idle got ov=%b dn=%b ir=%b want 0 0 1", out_valid, done, in_ready);
      end
    end
    rand_op(); load_op(0, 1'b0); collect(1'b0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_known_answers();
    test_relu();
    test_overflow();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/matmul_engine.md
MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 Parameter N, default 2: systolic array dimension (NxN PEs); legal 1..8.
REQ-002 Parameter DW, default 8: signed operand and output width.
REQ-003 Parameter ACCW, default 2*DW+$clog2(N)+1: signed accumulator width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  DW  signed matrix element, row-major stream.
REQ-007 in_valid  input  1  in_data valid this cycle.
REQ-008 in_ready  output  1  engine accepts an element this cycle.
REQ-009 transpose  input  1  1: compute X*W^T; 0: compute X*W.
REQ-010 activation  input  1  1: apply ReLU before output formatting.
REQ-011 out_data  output  DW  result element, row-major stream.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  consumer accepts out_data.
REQ-014 done  output  1  one-cycle pulse after final result is accepted.

Function
REQ-015 FSM states: IDLE, LOAD, COMPUTE, OUT; a load transfer occurs when in_valid && in_ready.
REQ-016 in_ready = 1 in IDLE and LOAD only; in_valid in COMPUTE/OUT is ignored without side effects.
REQ-017 IDLE->LOAD on the first transfer; transfers 0..N*N-1 fill W row-major, N*N..2*N*N-1 fill X row-major.
REQ-018 transpose and activation are latched on the final (2*N*N-th) transfer; later changes do not affect the current operation.
REQ-019 Final transfer in cycle t -> COMPUTE during cycles t+1..t+3N-1 (exactly 3N-1 cycles), skewed systolic feed, accumulators cleared at COMPUTE entry.
REQ-020 OUT entered at t+3N; out_valid = 1 throughout OUT; C[i][j] = sum over k of X[i][k]*W[k][j] (or W[j][k] when transpose) emitted i-major, j-minor.
REQ-021 Products and sums are signed, full precision in ACCW bits; no intermediate overflow for any legal N.
REQ-022 ReLU: negative accumulators become 0 before formatting.
REQ-023 Formatting without macro: out_data = low DW bits of (ReLU'd) accumulator.
REQ-024 Result index advances only on out_valid && out_ready; while out_ready = 0, out_data and out_valid hold stable indefinitely.
REQ-025 Handshake on result N*N-1 -> next cycle: state IDLE, out_valid = 0, done = 1 for exactly one cycle, in_ready = 1 (new load may be accepted in that same cycle).
REQ-026 N = 1: COMPUTE lasts 2 cycles, single-element output.
REQ-027 Memory/accumulator contents are not cleared between operations; every operation fully overwrites W and X.

Reset
REQ-028 rst_n low, at any time including mid-LOAD/COMPUTE/OUT: state = IDLE, load counter and output index = 0, accumulators = 0, in_ready = 0 while asserted, out_valid = 0, done = 0, out_data = 0.
REQ-029 First rising edge after rst_n deasserts: in_ready = 1; partial operations are discarded.

Configuration
REQ-030 Macro MATMUL_SAT_EN defined: formatting saturates the (ReLU'd) accumulator to signed DW range [-2^(DW-1), 2^(DW-1)-1].
REQ-031 MATMUL_SAT_EN undefined: formatting truncates per REQ-023; no saturation logic is synthesised.

Verification
REQ-032 N=2, W=[[1,2],[3,4]], X=[[5,6],[7,8]], transpose=0 -> out 23,34,31,46; first out_valid exactly 6 cycles after last load transfer.
REQ-033 Same data, transpose=1 -> out 17,39,23,53; done pulses once, one cycle after the 4th handshake.
REQ-034 W=[[-1,0],[0,-1]], X=[[3,0],[0,3]]: activation=1 -> 0,0,0,0; activation=0 -> 0xFD,0,0,0xFD.
REQ-035 All W and X = 127: MATMUL_SAT_EN defined -> four outputs 127 (0x7F); undefined -> four outputs 0x02.
REQ-036 out_ready toggled randomly, held low 20 cycles mid-stream -> out_data stable while stalled, values and order unchanged, in_valid pulses during OUT ignored.
REQ-037 rst_n pulsed low after 5 load transfers, then a full clean load -> results match a reset-free run; no out_valid or done during or after the aborted load.
